uart_rx: RTL and testbench

- UART receiver: mid-bit sampling of an asynchronous serial line; recovers DATA_BITS-wide words, LSB first, no parity, STOP_BITS stop bits.
- Counterpart of the existing UART transmitter; shares its parameters and frame format, so the loopback test drives this block from that transmitter's output.
- Delivers words over a valid/ready handshake and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame
// parameters, used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

    localparam int unsigned DEF_CLKS_PER_BIT = 1000;
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned DEF_STOP_BITS    = 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. The reset value
// is a parameter so an idle-high line can come out of reset as idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first data, no parity, checked stop
// bits, valid/ready output with framing-error and overrun pulses.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | line idle, waiting for a low level on the synchronised line
// START     | timing to the middle of the start bit to reject glitches
// DATA      | sampling data bits at their centres, LSB first
// STOP      | sampling stop bits; a low sample is a framing error
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS        = DEF_DATA_BITS,
    parameter int unsigned STOP_BITS        = DEF_STOP_BITS,
    parameter int unsigned CLKS_PER_BIT     = DEF_CLKS_PER_BIT,
    parameter int unsigned BIT_CTR_WIDTH    = $clog2(DATA_BITS),
    parameter int unsigned SAMPLE_CTR_WIDTH = $clog2(CLKS_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [SAMPLE_CTR_WIDTH-1:0] HALF_TC   = SAMPLE_CTR_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SAMPLE_CTR_WIDTH-1:0] FULL_TC   = SAMPLE_CTR_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CTR_WIDTH-1:0]    DATA_LAST = BIT_CTR_WIDTH'(DATA_BITS - 1);
    localparam logic [BIT_CTR_WIDTH-1:0]    STOP_LAST = BIT_CTR_WIDTH'(STOP_BITS - 1);

    uart_state_t                 state, state_nxt;
    logic [SAMPLE_CTR_WIDTH-1:0] sample_ctr, sample_ctr_nxt;
    logic [BIT_CTR_WIDTH-1:0]    bit_ctr, bit_ctr_nxt;
    logic [DATA_BITS-1:0]        shift_reg, shift_reg_nxt;
    logic                        rx_s;
    logic                        word_done;
    logic                        stop_fail;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (rx),
        .q       (rx_s)
    );

    // FSM state, sample/bit counters and the data shift register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= IDLE;
            sample_ctr <= '0;
            bit_ctr    <= '0;
            shift_reg  <= '0;
        end else begin
            state      <= state_nxt;
            sample_ctr <= sample_ctr_nxt;
            bit_ctr    <= bit_ctr_nxt;
            shift_reg  <= shift_reg_nxt;
        end
    end

    // Next-state logic; the sample counter restarts from 0 on every state change.
    always_comb begin
        state_nxt      = state;
        sample_ctr_nxt = sample_ctr;
        bit_ctr_nxt    = bit_ctr;
        shift_reg_nxt  = shift_reg;
        word_done      = 1'b0;
        stop_fail      = 1'b0;

        case (state)
            IDLE: begin
                sample_ctr_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (sample_ctr == HALF_TC) begin
                    sample_ctr_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_ctr_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    sample_ctr_nxt = sample_ctr + 1'b1;
                end
            end

            DATA: begin
                if (sample_ctr == FULL_TC) begin
                    sample_ctr_nxt = '0;
                    shift_reg_nxt  = {rx_s, shift_reg[DATA_BITS-1:1]};
                    if (bit_ctr == DATA_LAST) begin
                        state_nxt   = STOP;
                        bit_ctr_nxt = '0;
                    end else begin
                        bit_ctr_nxt = bit_ctr + 1'b1;
                    end
                end else begin
                    sample_ctr_nxt = sample_ctr + 1'b1;
                end
            end

            STOP: begin
                if (sample_ctr == FULL_TC) begin
                    sample_ctr_nxt = '0;
                    if (!rx_s) begin
                        stop_fail   = 1'b1;
                        state_nxt   = WAIT_HIGH;
                        bit_ctr_nxt = '0;
                    end else if (bit_ctr == STOP_LAST) begin
                        // Re-arm mid stop bit so back-to-back frames are caught.
                        word_done   = 1'b1;
                        state_nxt   = IDLE;
                        bit_ctr_nxt = '0;
                    end else begin
                        bit_ctr_nxt = bit_ctr + 1'b1;
                    end
                end else begin
                    sample_ctr_nxt = sample_ctr + 1'b1;
                end
            end

            WAIT_HIGH: begin
                sample_ctr_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt      = IDLE;
                sample_ctr_nxt = '0;
                bit_ctr_nxt    = '0;
            end
        endcase
    end

    // Output word, handshake and error pulses; a new word wins over an accept.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_fail;
            overrun   <= word_done && data_valid && !data_ready;
            if (word_done) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=16; a second instance
// with two stop bits covers the second-stop-bit framing check.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       n_reset;
    logic       rx, rx2;
    logic       data_ready, data_ready2;
    logic [7:0] data_out, data_out2;
    logic       data_valid, data_valid2;
    logic       frame_err, frame_err2;
    logic       overrun, overrun2;
    logic       busy, busy2;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0;
    int vld_cyc, vld_rise, ferr_cnt, ovr_cnt, rise_cyc;
    int vld_rise2, ferr_cnt2;
    logic [7:0] last_word, last_word2;
    logic dv_q = 1'b0, dv2_q = 1'b0;
    int t0;
    logic saw_busy;

    uart_rx #(
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    uart_rx #(
        .DATA_BITS    (8),
        .STOP_BITS    (2),
        .CLKS_PER_BIT (CPB)
    ) dut2 (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx         (rx2),
        .data_out   (data_out2),
        .data_valid (data_valid2),
        .data_ready (data_ready2),
        .frame_err  (frame_err2),
        .overrun    (overrun2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse/word monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid) vld_cyc++;
        if (data_valid && !dv_q) begin
            vld_rise++;
            last_word = data_out;
            rise_cyc  = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        dv_q = data_valid;
    end

    always @(negedge clk) begin
        if (data_valid2 && !dv2_q) begin
            vld_rise2++;
            last_word2 = data_out2;
        end
        if (frame_err2) ferr_cnt2++;
        dv2_q = data_valid2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        vld_cyc   = 0;
        vld_rise  = 0;
        ferr_cnt  = 0;
        ovr_cnt   = 0;
        vld_rise2 = 0;
        ferr_cnt2 = 0;
        last_word = 8'h00;
        last_word2 = 8'h00;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx  = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; stop bits taken from stops[0], stops[1].
    task automatic send_frame(input bit sel, input logic [7:0] d, input int nstop,
                              input logic [1:0] stops);
        drive(sel, 1'b0);
        t0 = cyc + 1;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            cycles(CPB);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(sel, stops[i]);
            cycles(CPB);
        end
    endtask

    initial begin
        n_reset     = 1'b0;
        rx          = 1'b1;
        rx2         = 1'b1;
        data_ready  = 1'b0;
        data_ready2 = 1'b1;
        clr_counts();
        cycles(3);

        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        n_reset = 1'b1;
        cycles(5);

        // Single word with consumer ready.
        clr_counts();
        data_ready = 1'b1;
        send_frame(1'b0, 8'hA5, 1, 2'b11);
        cycles(5);
        chk("a5_word", 32'(last_word), 32'hA5);
        chk("a5_valid_cycles", 32'(vld_cyc), 32'd1);
        chk("a5_frame_err", 32'(ferr_cnt), 32'd0);
        chk("a5_overrun", 32'(ovr_cnt), 32'd0);
        chk("a5_latency_window",
            32'((rise_cyc - t0) >= 147 && (rise_cyc - t0) <= 155), 32'd1);
        chk("a5_busy_after", 32'(busy), 32'h0);

        // Back-to-back words, consumer stalled.
        clr_counts();
        data_ready = 1'b0;
        send_frame(1'b0, 8'h3C, 1, 2'b11);
        send_frame(1'b0, 8'h81, 1, 2'b11);
        cycles(4);
        chk("b2b_first_word", 32'(last_word), 32'h3C);
        chk("b2b_data_out", 32'(data_out), 32'h81);
        chk("b2b_valid_held", 32'(data_valid), 32'h1);
        chk("b2b_overrun_pulses", 32'(ovr_cnt), 32'd1);
        chk("b2b_frame_err", 32'(ferr_cnt), 32'd0);
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;
        chk("b2b_accept_clears", 32'(data_valid), 32'h0);

        // Start-bit glitch.
        clr_counts();
        rx = 1'b0;
        cycles(4);
        saw_busy = busy;
        rx = 1'b1;
        cycles(8);
        chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
        chk("glitch_busy_clear", 32'(busy), 32'h0);
        cycles(20);
        chk("glitch_no_valid", 32'(vld_rise), 32'd0);
        chk("glitch_no_frame_err", 32'(ferr_cnt), 32'd0);

        // Low stop bit followed by a break.
        clr_counts();
        send_frame(1'b0, 8'h55, 1, 2'b00);
        cycles(40);
        chk("break_busy_waiting", 32'(busy), 32'h1);
        rx = 1'b1;
        cycles(10);
        chk("break_frame_err_pulses", 32'(ferr_cnt), 32'd1);
        chk("break_no_valid", 32'(vld_rise), 32'd0);
        chk("break_busy_clear", 32'(busy), 32'h0);
        send_frame(1'b0, 8'h12, 1, 2'b11);
        cycles(4);
        chk("after_break_word", 32'(data_out), 32'h12);
        chk("after_break_valid", 32'(data_valid), 32'h1);

        // Reset in the middle of data bit 3 of 0xFF.
        clr_counts();
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b1;
        cycles(3 * CPB + CPB / 2);
        chk("mid_busy", 32'(busy), 32'h1);
        n_reset = 1'b0;
        cycles(1);
        chk("mid_rst_data_out", 32'(data_out), 32'h00);
        chk("mid_rst_valid", 32'(data_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_pulses", 32'(frame_err | overrun), 32'h0);
        n_reset = 1'b1;
        cycles(CPB * 6);
        chk("mid_no_pulses", 32'(ferr_cnt + ovr_cnt + vld_rise), 32'd0);
        data_ready = 1'b1;
        send_frame(1'b0, 8'h0F, 1, 2'b11);
        cycles(4);
        chk("after_rst_word", 32'(last_word), 32'h0F);
        chk("after_rst_valid_rises", 32'(vld_rise), 32'd1);

        // Two stop bits: good frame, then second stop bit low.
        clr_counts();
        send_frame(1'b1, 8'h5A, 2, 2'b11);
        cycles(4);
        chk("sb2_good_word", 32'(last_word2), 32'h5A);
        chk("sb2_good_frame_err", 32'(ferr_cnt2), 32'd0);
        clr_counts();
        send_frame(1'b1, 8'hC3, 2, 2'b01);
        rx2 = 1'b1;
        cycles(10);
        chk("sb2_frame_err", 32'(ferr_cnt2), 32'd1);
        chk("sb2_no_valid", 32'(vld_rise2), 32'd0);
        chk("sb2_busy_clear", 32'(busy2), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
